// File: rtl/ex_md_stage_pkg.sv
// Shared encodings for the EX stage and its iterative multiply/divide unit.
package ex_md_stage_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MA  = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam logic [1:0] FWD_RF2 = 2'b11;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

endpackage

// File: rtl/ex_md_stage_md_unit.sv
// Radix-2 iterative multiplier/divider on operand magnitudes, sign fixed at the end.
module md_unit
   import ex_md_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);

   md_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
   logic [XLEN-1:0]   m_q, m_d;
   logic [2*XLEN-1:0] p_q, p_d;

   logic            a_sgn, b_sgn, ge;
   logic [XLEN-1:0] a_mag, b_mag, sub;
   logic [XLEN:0]   add_s, rem_s;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (op_i)
         F3_MULH, F3_DIV, F3_REM: begin
            a_sgn = a_i[XLEN-1];
            b_sgn = b_i[XLEN-1];
         end
         F3_MULHSU: a_sgn = a_i[XLEN-1];
         default: ;
      endcase
      a_mag = a_sgn ? -a_i : a_i;
      b_mag = b_sgn ? -b_i : b_i;
   end

   // p_q holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      add_s = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
      rem_s = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
      ge    = rem_s >= {1'b0, m_q};
      sub   = rem_s[XLEN-1:0] - m_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      m_d     = m_q;
      p_d     = p_q;
      if (flush_i) begin
         state_d = MD_IDLE;
      end else begin
         unique case (state_q)
            MD_IDLE: if (start_i) begin
               state_d = MD_BUSY;
               cnt_d   = CW'(XLEN - 1);
               op_d    = op_i;
               sa_d    = a_sgn;
               sb_d    = b_sgn;
               dz_d    = (b_i == '0);
               m_d     = op_i[2] ? b_mag : a_mag;
               p_d     = {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
            end
            MD_BUSY: begin
               if (op_q[2])
                  p_d = {(ge ? sub : rem_s[XLEN-1:0]), p_q[XLEN-2:0], ge};
               else
                  p_d = {add_s, p_q[XLEN-1:1]};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0)
                  state_d = MD_DONE;
            end
            default: state_d = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         m_q     <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         m_q     <= m_d;
         p_q     <= p_d;
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   always_comb begin
      prod     = (sa_q ^ sb_q) ? -p_q : p_q;
      quo      = (sa_q ^ sb_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
      rem      = sa_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
      result_o = '0;
      unique case (op_q)
         F3_MUL:                      result_o = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             result_o = dz_q ? '1 : quo;
         default:                     result_o = rem;
      endcase
   end

   assign busy_o = (state_q == MD_BUSY);
   assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/ex_md_stage.sv
// EX stage: operand forwarding, single-cycle ALU and optional stalling M unit.
module ex_md_stage
   import ex_md_stage_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int MD_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pcPlus4_in,
   input  logic [XLEN-1:0] DataA_in,
   input  logic [XLEN-1:0] DataB_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic [XLEN-1:0] ALU_Result_in,
   input  logic [XLEN-1:0] WB_Result_in,
   input  logic [4:0]      AddrD_in,
   input  logic            RegWEn_in,
   input  logic            ASel_in,
   input  logic            BSel_in,
   input  logic            MemRW_in,
   input  logic            MDEn_in,
   input  logic [3:0]      ALUSel_in,
   input  logic [1:0]      WBSel_in,
   input  logic [2:0]      funct3_in,
   input  logic [1:0]      fwdSelA,
   input  logic [1:0]      fwdSelB,
   input  logic            flush_in,
   output logic            stall_out,
   output logic            RegWEn_out,
   output logic            MemRW_out,
   output logic [1:0]      WBSel_out,
   output logic [2:0]      funct3_out,
   output logic [4:0]      AddrD_out,
   output logic [XLEN-1:0] ALU_Result_out,
   output logic [XLEN-1:0] DataB_out,
   output logic [XLEN-1:0] pcPlus4_out
);

   localparam int SW = $clog2(XLEN);

   function automatic logic [XLEN-1:0] fwd_mux(
      input logic [1:0]      sel,
      input logic [XLEN-1:0] rf,
      input logic [XLEN-1:0] ma,
      input logic [XLEN-1:0] wb
   );
      unique case (sel)
         FWD_MA:  return ma;
         FWD_WB:  return wb;
         default: return rf;
      endcase
   endfunction

   logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res;
   logic [SW-1:0]   shamt;

   assign fwd_a = fwd_mux(fwdSelA, DataA_in, ALU_Result_in, WB_Result_in);
   assign fwd_b = fwd_mux(fwdSelB, DataB_in, ALU_Result_in, WB_Result_in);
   assign alu_a = ASel_in ? pc_in : fwd_a;
   assign alu_b = BSel_in ? imm_in : fwd_b;
   assign shamt = alu_b[SW-1:0];

   always_comb begin
      alu_res = '0;
      unique case (ALUSel_in)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_SLL:  alu_res = alu_a << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SRL:  alu_res = alu_a >> shamt;
         ALU_SRA:  alu_res = $signed(alu_a) >>> shamt;
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         default:  alu_res = alu_b;
      endcase
   end

   logic            md_start, md_busy, md_done;
   logic [XLEN-1:0] md_res;

   if (MD_EN != 0) begin : g_md
      assign md_start = MDEn_in & ~flush_in;
      md_unit #(.XLEN(XLEN)) u_md (
         .clk_i    (clk),
         .reset_i  (reset),
         .flush_i  (flush_in),
         .start_i  (md_start),
         .op_i     (funct3_in),
         .a_i      (fwd_a),
         .b_i      (fwd_b),
         .busy_o   (md_busy),
         .done_o   (md_done),
         .result_o (md_res)
      );
   end else begin : g_no_md
      logic unused_md;
      assign unused_md = MDEn_in;
      assign md_start  = 1'b0;
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_res    = '0;
   end

   // The IDLE->BUSY cycle stalls too, DONE releases the pipe
   assign stall_out = ~reset & ~flush_in & (md_busy | (md_start & ~md_done));

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush_in || stall_out) begin
         RegWEn_out     <= 1'b0;
         MemRW_out      <= 1'b0;
         WBSel_out      <= '0;
         funct3_out     <= '0;
         AddrD_out      <= '0;
         ALU_Result_out <= '0;
         DataB_out      <= '0;
         pcPlus4_out    <= '0;
      end else begin
         RegWEn_out     <= RegWEn_in;
         MemRW_out      <= MemRW_in;
         WBSel_out      <= WBSel_in;
         funct3_out     <= funct3_in;
         AddrD_out      <= AddrD_in;
         ALU_Result_out <= md_done ? md_res : alu_res;
         DataB_out      <= fwd_b;
         pcPlus4_out    <= pcPlus4_in;
      end
   end

endmodule

// File: tb/tb_ex_md_stage.sv
// Randomised self-checking bench for ex_md_stage against an arithmetic reference.
module tb_ex_md_stage;
   import ex_md_stage_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [XLEN-1:0] pc_in, pcPlus4_in, DataA_in, DataB_in, imm_in;
   logic [XLEN-1:0] ALU_Result_in, WB_Result_in;
   logic [4:0]      AddrD_in;
   logic            RegWEn_in, ASel_in, BSel_in, MemRW_in, MDEn_in;
   logic [3:0]      ALUSel_in;
   logic [1:0]      WBSel_in;
   logic [2:0]      funct3_in;
   logic [1:0]      fwdSelA, fwdSelB;
   logic            flush_in;
   logic            stall_out, RegWEn_out, MemRW_out;
   logic [1:0]      WBSel_out;
   logic [2:0]      funct3_out;
   logic [4:0]      AddrD_out;
   logic [XLEN-1:0] ALU_Result_out, DataB_out, pcPlus4_out;

   ex_md_stage #(.XLEN(XLEN), .MD_EN(1)) dut (
      .clk(clk), .reset(reset),
      .pc_in(pc_in), .pcPlus4_in(pcPlus4_in),
      .DataA_in(DataA_in), .DataB_in(DataB_in), .imm_in(imm_in),
      .ALU_Result_in(ALU_Result_in), .WB_Result_in(WB_Result_in),
      .AddrD_in(AddrD_in), .RegWEn_in(RegWEn_in), .ASel_in(ASel_in),
      .BSel_in(BSel_in), .MemRW_in(MemRW_in), .MDEn_in(MDEn_in),
      .ALUSel_in(ALUSel_in), .WBSel_in(WBSel_in), .funct3_in(funct3_in),
      .fwdSelA(fwdSelA), .fwdSelB(fwdSelB), .flush_in(flush_in),
      .stall_out(stall_out), .RegWEn_out(RegWEn_out), .MemRW_out(MemRW_out),
      .WBSel_out(WBSel_out), .funct3_out(funct3_out), .AddrD_out(AddrD_out),
      .ALU_Result_out(ALU_Result_out), .DataB_out(DataB_out),
      .pcPlus4_out(pcPlus4_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] fa, fb;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa = $signed(a);
      longint          sb = $signed(b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      logic [63:0]     p;
      logic            ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return b;
      endcase
   endfunction

   // Place the wanted operands behind randomly chosen forwarding sources
   task automatic set_op(input logic md, input logic [2:0] f3, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
      logic [1:0] sa, sb;
      sa = 2'($urandom_range(0, 3));
      sb = 2'($urandom_range(0, 3));
      if (sa == sb && (sa == 2'd1 || sa == 2'd2)) sb = 2'd0;
      pc_in = $urandom; pcPlus4_in = $urandom; imm_in = $urandom;
      DataA_in = $urandom; DataB_in = $urandom;
      ALU_Result_in = $urandom; WB_Result_in = $urandom;
      case (sa)
         2'd1: ALU_Result_in = a;
         2'd2: WB_Result_in = a;
         default: DataA_in = a;
      endcase
      case (sb)
         2'd1: ALU_Result_in = b;
         2'd2: WB_Result_in = b;
         default: DataB_in = b;
      endcase
      fwdSelA = sa; fwdSelB = sb;
      fa = a; fb = b;
      ASel_in = 1'($urandom_range(0, 1));
      BSel_in = 1'($urandom_range(0, 1));
      MDEn_in = md; funct3_in = f3; ALUSel_in = sel;
      RegWEn_in = 1'b1; MemRW_in = 1'($urandom_range(0, 1));
      WBSel_in = 2'($urandom_range(0, 3));
      AddrD_in = 5'($urandom_range(1, 31));
   endtask

   function automatic logic [43:0] ctl_now();
      return {RegWEn_in, MemRW_in, WBSel_in, funct3_in, AddrD_in, pcPlus4_in};
   endfunction

   function automatic logic [43:0] ctl_out();
      return {RegWEn_out, MemRW_out, WBSel_out, funct3_out, AddrD_out, pcPlus4_out};
   endfunction

   task automatic run_alu(input string tag);
      logic [31:0] exp;
      logic [43:0] ctl;
      exp = alu_ref(ALUSel_in, ASel_in ? pc_in : fa, BSel_in ? imm_in : fb);
      ctl = ctl_now();
      #1;
      check({tag, "_stall"}, stall_out, 0);
      @(posedge clk); #1;
      check(tag, ALU_Result_out, exp);
      check({tag, "_ctl"}, ctl_out(), ctl);
      check({tag, "_datab"}, DataB_out, fb);
   endtask

   task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int          stalls;
      int          bub_bad;
      logic [31:0] exp;
      logic [43:0] ctl;
      set_op(1'b1, f3, 4'($urandom_range(0, 10)), a, b);
      exp = m_ref(f3, a, b);
      ctl = ctl_now();
      stalls = 0;
      bub_bad = 0;
      #1;
      while (stall_out && stalls < 200) begin
         stalls++;
         @(posedge clk); #1;
         if (ctl_out() != 0 || ALU_Result_out != 0 || DataB_out != 0) bub_bad++;
      end
      check({tag, "_stall_len"}, stalls, XLEN + 1);
      check({tag, "_bubble"}, bub_bad, 0);
      @(posedge clk); #1;
      check(tag, ALU_Result_out, exp);
      check({tag, "_ctl"}, ctl_out(), ctl);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      flush_in = 1'b0;
      set_op(1'b0, 3'd0, ALU_ADD, 32'd0, 32'd0);
      RegWEn_in = 1'b0;
      #12;
      check("rst_res", ALU_Result_out, 0);
      check("rst_ctl", ctl_out(), 0);
      check("rst_stall", stall_out, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      set_op(1'b0, 3'd0, ALU_ADD, 32'd5, 32'd7);
      fwdSelA = FWD_MA; ALU_Result_in = 32'd5; DataA_in = 32'h1234;
      fwdSelB = FWD_RF; DataB_in = 32'd7; WB_Result_in = 32'h99;
      ASel_in = 1'b0; BSel_in = 1'b0;
      run_alu("add_fwd");

      run_md("mul",    F3_MUL,    32'hFFFF_FFFF, 32'd2);
      run_md("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'd2);
      run_md("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'd2);
      run_md("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2);
      run_md("div_ov", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
      run_md("rem_ov", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF);
      run_md("divu_z", F3_DIVU,   32'd7, 32'd0);
      run_md("remu_z", F3_REMU,   32'd7, 32'd0);
      run_md("div_z",  F3_DIV,    32'hFFFF_FFF9, 32'd0);
      run_md("rem_z",  F3_REM,    32'hFFFF_FFF9, 32'd0);
      run_md("div_n",  F3_DIV,    32'hFFFF_FFF9, 32'd2);
      run_md("rem_n",  F3_REM,    32'hFFFF_FFF9, 32'd2);

      // flush in the tenth BUSY cycle
      set_op(1'b1, F3_DIV, ALU_ADD, 32'd100, 32'd7);
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      check("flush_busy", stall_out, 1);
      flush_in = 1'b1;
      #1;
      check("flush_stall", stall_out, 0);
      @(posedge clk); #1;
      check("flush_bubble", ctl_out(), 0);
      flush_in = 1'b0;
      set_op(1'b0, 3'd0, ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
      run_alu("post_flush");

      // reset in the middle of a BUSY phase
      set_op(1'b1, F3_MUL, ALU_ADD, 32'd123, 32'd456);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst_busy_stall", stall_out, 0);
      check("rst_busy_out", {ctl_out(), ALU_Result_out}, 0);
      #1;
      reset = 1'b0;
      set_op(1'b0, 3'd0, ALU_SUB, 32'd1000, 32'd1);
      run_alu("post_rst");

      // asynchronous clear of a freshly loaded non-zero result
      #2;
      reset = 1'b1;
      #1;
      check("rst_async", {ctl_out(), ALU_Result_out, DataB_out}, 0);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         int          k;
         a = $urandom;
         b = $urandom;
         k = $urandom_range(0, 5);
         if (k == 0) b = 32'd0;
         if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (k == 2) b = 32'($urandom_range(1, 9));
         if ($urandom_range(0, 2) == 0) begin
            set_op(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 10)), a, b);
            run_alu("rnd_alu");
         end else begin
            run_md("rnd_md", 3'($urandom_range(0, 7)), a, b);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_md_stage.md
EX_MD_STAGE -- requirements
Module: ex_md_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width (32 or 64).
REQ-002 SHALL have parameter MD_EN, default 1, meaning the M-extension unit is instantiated (0 = absent, MDEn_in ignored).
REQ-003 SHALL have ports:
 - clk  in  1  rising-edge clock
 - reset  in  1  asynchronous, active-high
 - pc_in, pcPlus4_in, DataA_in, DataB_in, imm_in  in  XLEN each  ID/EX operands
 - ALU_Result_in, WB_Result_in  in  XLEN each  forwarded values from MA and WB
 - AddrD_in  in  5  destination register
 - RegWEn_in, ASel_in, BSel_in, MemRW_in, MDEn_in  in  1 each  controls; MDEn_in marks a MUL/DIV/REM op
 - ALUSel_in  in  4;  WBSel_in  in  2;  funct3_in  in  3;  fwdSelA, fwdSelB  in  2 each
 - flush_in  in  1  kill the instruction in EX
 - stall_out  out  1  upstream must hold PC, IF/ID, ID/EX
 - RegWEn_out, MemRW_out  out  1;  WBSel_out  out  2;  funct3_out  out  3;  AddrD_out  out  5
 - ALU_Result_out, DataB_out, pcPlus4_out  out  XLEN  registered EX/MA fields

Function
REQ-004 fwdSel: 00 = Data*_in, 01 = ALU_Result_in, 10 = WB_Result_in, 11 = Data*_in.
REQ-005 ALU input A = pc_in if ASel_in else forwarded A; input B = imm_in if BSel_in else forwarded B.
REQ-006 DataB_out SHALL latch forwarded B (not the imm-muxed value).
REQ-007 MDEn_in=0: EX/MA loads all fields at the next edge; latency 1; stall_out=0.
REQ-008 M-unit FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-009 IDLE with MDEn_in=1 and flush_in=0: stall_out=1 combinationally; at edge capture forwarded A/B and funct3_in, counter=XLEN-1, go to BUSY.
REQ-010 BUSY: one radix-2 iteration per cycle, stall_out=1; at counter 0 go to DONE; exactly XLEN BUSY cycles.
REQ-011 DONE: stall_out=0, EX/MA loads M result plus control fields at the edge, FSM to IDLE; stall_out is high XLEN+1 consecutive cycles per M op.
REQ-012 While stall_out=1, EX/MA SHALL load a bubble: RegWEn_out=0, MemRW_out=0, AddrD_out=0, other fields 0.
REQ-013 funct3 000 MUL low XLEN, 001 MULH s*s high, 010 MULHSU s*u high, 011 MULHU u*u high, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-014 Divide by zero: DIV/DIVU = all ones, REM/REMU = dividend.
REQ-015 Signed overflow (-2^(XLEN-1) / -1): DIV = dividend, REM = 0.
REQ-016 Special cases SHALL take the same XLEN+2 cycle latency (constant latency).
REQ-017 Remainder sign follows dividend; quotient truncates toward zero.
REQ-018 flush_in has highest priority: any state to IDLE at the edge, stall_out forced 0 that cycle, EX/MA loads a bubble.
REQ-019 Back-to-back M ops: the next op, presented in the cycle after DONE, starts from IDLE normally.
REQ-020 MD_EN=0: MDEn_in ignored; op executes as the ALU op given by ALUSel_in.

Reset
REQ-021 reset SHALL asynchronously clear all EX/MA outputs to 0, set the FSM to IDLE and counter/operand registers to 0; stall_out=0 during reset.
REQ-022 Reset mid-BUSY discards the operation; no partial result reaches EX/MA.

Structure
REQ-023 Shared package holds XLEN default, FSM state enum, M funct3 encodings and fwdSel codes.
REQ-024 Iterative multiplier/divider SHALL be one sub-module, md_unit (start, op, a, b -> busy, done, result); the existing ALU and MUX modules are reused.

Verification
REQ-025 ADD, fwdSelA=01, ALU_Result_in=5, DataB_in=7 -> next cycle ALU_Result_out=12, stall_out never high.
REQ-026 MUL A=0xFFFFFFFF, B=2 -> stall_out high 33 cycles, then ALU_Result_out=0xFFFFFFFE; MULHU same operands -> 0x00000001; MULH -> 0xFFFFFFFF.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; all at full latency.
REQ-028 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; bubbles (RegWEn_out=0) during every stall cycle.
REQ-029 flush_in at BUSY cycle 10 -> stall_out 0 that cycle, FSM IDLE, no result written; reset asserted mid-BUSY -> all outputs 0 immediately.
